// File: rtl/dm_ctrl_pkg.sv
// Shared types and lane helpers for the data-memory access controller.
// Width codes follow the Mem2Reg encoding: 01 word, 10 half, 11 byte.
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_WORD = 2'b01;
    localparam logic [1:0] W_HALF = 2'b10;
    localparam logic [1:0] W_BYTE = 2'b11;

    function automatic logic [3:0] be_gen(input logic [1:0] wr, input logic [1:0] off);
        case (wr)
            W_WORD:  be_gen = 4'b1111;
            W_HALF:  be_gen = off[1] ? 4'b1100 : 4'b0011;
            W_BYTE:  be_gen = 4'b0001 << off;
            default: be_gen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] wdata_rep(input logic [1:0] wr, input logic [31:0] d);
        case (wr)
            W_WORD:  wdata_rep = d;
            W_HALF:  wdata_rep = {2{d[15:0]}};
            W_BYTE:  wdata_rep = {4{d[7:0]}};
            default: wdata_rep = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_access_ctrl_ld_extend.sv
// Load-lane selection and sign/zero extension of a returned bus word.
module ld_extend
    import dm_ctrl_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  width_i,
    input  logic [1:0]  off_i,
    input  logic        uns_i,
    output logic [31:0] ext_o
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (off_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        case (width_i)
            W_HALF:  ext_o = {{16{half_sel[15] & ~uns_i}}, half_sel};
            W_BYTE:  ext_o = {{24{byte_sel[7] & ~uns_i}}, byte_sel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage load/store sequencer onto a req/ack data bus with timeout.
// Optional macro MEM_ALIGN_EXC_EN enables misaligned-address exceptions.
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_rd,
    input  logic [1:0]  mem_wr,
    input  logic        ld_uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        done,
    output logic        bus_err,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q;
    logic [1:0]  rd_q, wr_q;
    logic        uns_q, err_q;
    logic [31:0] addr_q, wdata_q, ld_data_q, ext_word;
    logic        misaligned, start, timeout_hit;

`ifdef MEM_ALIGN_EXC_EN
    assign misaligned = ((mem_rd == W_WORD || mem_wr == W_WORD) && addr[1:0] != 2'b00)
                     || ((mem_rd == W_HALF || mem_wr == W_HALF) && addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    assign start       = (mem_rd != W_NONE || mem_wr != W_NONE) && !misaligned;
    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = REQ;
            REQ:     if (bus_ack || timeout_hit) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req  = (state_q == REQ);
        stall    = (state_q == REQ) || (state_q == IDLE && start);
        done     = (state_q == DONE);
        bus_err  = (state_q == DONE) && err_q;
        exc_adel = (state_q == IDLE) && misaligned && (mem_rd != W_NONE);
        exc_ades = (state_q == IDLE) && misaligned && (mem_wr != W_NONE);
    end

    // Latched operation plus the load result register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_q      <= W_NONE;
            wr_q      <= W_NONE;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    rd_q    <= mem_rd;
                    wr_q    <= mem_wr;
                    uns_q   <= ld_uns;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                end
                REQ: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (bus_ack) begin
                        if (rd_q != W_NONE) ld_data_q <= ext_word;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ld_extend u_ld_extend (
        .rdata_i (bus_rdata),
        .width_i (rd_q),
        .off_i   (addr_q[1:0]),
        .uns_i   (uns_q),
        .ext_o   (ext_word)
    );

    assign ld_data   = ld_data_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? be_gen(wr_q, addr_q[1:0]) : 4'b0000;
    assign bus_wdata = bus_req ? wdata_rep(wr_q, wdata_q) : 32'd0;

endmodule
